// File: rtl/hc_pkg.sv
// Shared types for the hc buffer slots: line payload, occupancy width, status and command.
package hc_pkg;

    localparam int HC_BUFFER_DEPTH = 64;
    localparam int HC_LINE_W       = 512;

    typedef logic [HC_LINE_W-1:0]              t_buffer_data;
    typedef logic [$clog2(HC_BUFFER_DEPTH):0]  t_buffer_size;

    typedef enum logic [1:0] {
        e_BUFFER_IDLE    = 2'd0,
        e_BUFFER_ENQUEUE = 2'd1,
        e_BUFFER_DEQUEUE = 2'd2
    } t_buffer_cmd;

    typedef struct packed {
        t_buffer_cmd cmd;
    } t_buffer_control;

    typedef struct packed {
        t_buffer_size count;
        logic         empty;
        logic         full;
    } t_buffer_status;

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/hc_buffer_ram.sv
// Line storage for one buffer slot: one write port, asynchronous read of the head entry.
module hc_buffer_ram
    import hc_pkg::*;
#(
    parameter int DEPTH = HC_BUFFER_DEPTH
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  t_buffer_data             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output t_buffer_data             rd_data
);

    t_buffer_data mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/hc_buffer_responder.sv
// Buffer-side responder for one hc buffer slot: user enqueue/dequeue, reserve-then-fill from
// read responses, and show-ahead drain toward the write engine.
module hc_buffer_responder
    import hc_pkg::*;
#(
    parameter int DEPTH   = HC_BUFFER_DEPTH,
    parameter int COUNT_W = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  t_buffer_control control,
    input  t_buffer_data    enq_data,
    output t_buffer_data    head_data,
    output t_buffer_status  status,
    input  logic            alloc_valid,
    output logic            alloc_grant,
    input  logic            fill_valid,
    input  t_buffer_data    fill_data,
    output logic            fill_ready,
    output logic            drain_valid,
    output t_buffer_data    drain_data,
    input  logic            drain_ready,
    output logic            err_overflow,
    output logic            err_underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [COUNT_W:0] DEPTH_EXT = (COUNT_W + 1)'(DEPTH);

    // The occupancy fields must fit inside the shared status count.
    if (!is_pow2(DEPTH) || COUNT_W != PTR_W + 1 || COUNT_W > $bits(t_buffer_size)) begin : g_bad_params
        $error("hc_buffer_responder: DEPTH must be a power of 2 >= 2 and COUNT_W must fit t_buffer_size");
    end

    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [COUNT_W-1:0] count_q, reserved_q, count_n, reserved_n;
    logic [COUNT_W:0]   occupancy;
    logic               empty_q, full_q, err_ov_q, err_un_q;
    logic               is_enq, is_deq;
    logic               user_push, fill_push, push, user_pop, drain_pop, pop;
    logic               overflow, underflow;
    t_buffer_data       wr_data;

    always_comb begin
        is_enq      = (control.cmd == e_BUFFER_ENQUEUE);
        is_deq      = (control.cmd == e_BUFFER_DEQUEUE);
        user_push   = is_enq && !full_q;
        fill_ready  = !is_enq;
        fill_push   = fill_valid && fill_ready && (reserved_q != '0);
        overflow    = (is_enq && full_q) || (fill_valid && fill_ready && (reserved_q == '0));
        // A same-cycle user push takes one of the free slots before the reservation does.
        occupancy   = {1'b0, count_q} + {1'b0, reserved_q} + {{COUNT_W{1'b0}}, user_push};
        alloc_grant = alloc_valid && (occupancy < DEPTH_EXT);
        drain_valid = !empty_q && !is_deq;
        drain_pop   = drain_valid && drain_ready;
        user_pop    = is_deq && !empty_q;
        underflow   = is_deq && empty_q;
        push        = user_push || fill_push;
        pop         = user_pop || drain_pop;
        count_n     = count_q + COUNT_W'(push) - COUNT_W'(pop);
        reserved_n  = reserved_q + COUNT_W'(alloc_grant) - COUNT_W'(fill_push);
        wr_data     = is_enq ? enq_data : fill_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            reserved_q <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            err_ov_q   <= 1'b0;
            err_un_q   <= 1'b0;
        end else begin
            count_q    <= count_n;
            reserved_q <= reserved_n;
            empty_q    <= (count_n == '0);
            full_q     <= (({1'b0, count_n} + {1'b0, reserved_n}) == DEPTH_EXT);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (overflow) begin
                err_ov_q <= 1'b1;
            end
            if (underflow) begin
                err_un_q <= 1'b1;
            end
        end
    end

    hc_buffer_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (push),
        .wr_addr(wr_ptr_q),
        .wr_data(wr_data),
        .rd_addr(rd_ptr_q),
        .rd_data(head_data)
    );

    assign drain_data    = head_data;
    assign status        = '{count: t_buffer_size'(count_q), empty: empty_q, full: full_q};
    assign err_overflow  = err_ov_q;
    assign err_underflow = err_un_q;

endmodule

// File: tb/tb_hc_buffer_responder.sv
// Directed bench for hc_buffer_responder at DEPTH=4.
module tb_hc_buffer_responder;
    import hc_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    t_buffer_control control;
    t_buffer_data    enq_data;
    t_buffer_data    head_data;
    t_buffer_status  status;
    logic            alloc_valid;
    logic            alloc_grant;
    logic            fill_valid;
    t_buffer_data    fill_data;
    logic            fill_ready;
    logic            drain_valid;
    t_buffer_data    drain_data;
    logic            drain_ready;
    logic            err_overflow;
    logic            err_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    hc_buffer_responder #(
        .DEPTH  (4),
        .COUNT_W(3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .control      (control),
        .enq_data     (enq_data),
        .head_data    (head_data),
        .status       (status),
        .alloc_valid  (alloc_valid),
        .alloc_grant  (alloc_grant),
        .fill_valid   (fill_valid),
        .fill_data    (fill_data),
        .fill_ready   (fill_ready),
        .drain_valid  (drain_valid),
        .drain_data   (drain_data),
        .drain_ready  (drain_ready),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_status(input string tag, input int cnt, input bit emp, input bit ful);
        chk({tag, ".count"}, 512'(status.count), 512'(cnt));
        chk({tag, ".empty"}, 512'(status.empty), 512'(emp));
        chk({tag, ".full"},  512'(status.full),  512'(ful));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        control.cmd = e_BUFFER_IDLE;
        enq_data    = '0;
        alloc_valid = 1'b0;
        fill_valid  = 1'b0;
        fill_data   = '0;
        drain_ready = 1'b0;
        do_reset();

        chk_status("reset", 0, 1'b1, 1'b0);
        chk("reset.err_ov", 512'(err_overflow), 512'(0));
        chk("reset.err_un", 512'(err_underflow), 512'(0));
        chk("reset.drain_valid", 512'(drain_valid), 512'(0));

        // Fill by user enqueue: A, B, C, D.
        for (int i = 0; i < 4; i++) begin
            control.cmd = e_BUFFER_ENQUEUE;
            enq_data    = 512'(32'hA + i);
            tick();
            chk("enq.count", 512'(status.count), 512'(i + 1));
        end
        chk("enq4.full", 512'(status.full), 512'(1));
        chk("enq4.head", head_data, 512'hA);
        enq_data = 512'hE;
        settle();
        chk("enq.fill_ready", 512'(fill_ready), 512'(0));
        tick();
        chk("enq5.err_ov", 512'(err_overflow), 512'(1));
        chk("enq5.count", 512'(status.count), 512'(4));
        control.cmd = e_BUFFER_IDLE;
        settle();
        chk("idle.drain_valid", 512'(drain_valid), 512'(1));

        // Drain by user dequeue, head order A..D.
        for (int i = 0; i < 4; i++) begin
            control.cmd = e_BUFFER_DEQUEUE;
            settle();
            chk("deq.head", head_data, 512'(32'hA + i));
            chk("deq.drain_valid", 512'(drain_valid), 512'(0));
            tick();
            chk("deq.count", 512'(status.count), 512'(3 - i));
        end
        chk("deq4.empty", 512'(status.empty), 512'(1));
        chk("deq4.err_un", 512'(err_underflow), 512'(0));
        tick();
        chk("deq5.err_un", 512'(err_underflow), 512'(1));
        chk("deq5.count", 512'(status.count), 512'(0));
        control.cmd = e_BUFFER_IDLE;

        do_reset();
        chk("rst2.err_ov", 512'(err_overflow), 512'(0));
        chk("rst2.err_un", 512'(err_underflow), 512'(0));

        // Reserve four slots, fifth request refused.
        alloc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("alloc.grant", 512'(alloc_grant), 512'(i < 4));
            tick();
        end
        alloc_valid = 1'b0;
        chk_status("alloc4", 0, 1'b1, 1'b1);

        for (int i = 0; i < 4; i++) begin
            fill_valid = 1'b1;
            fill_data  = 512'(32'h10 + i);
            settle();
            chk("fill.ready", 512'(fill_ready), 512'(1));
            tick();
            chk("fill.count", 512'(status.count), 512'(i + 1));
        end
        fill_valid = 1'b0;
        chk_status("fill4", 4, 1'b0, 1'b1);
        chk("fill4.err_ov", 512'(err_overflow), 512'(0));

        drain_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("drain.valid", 512'(drain_valid), 512'(1));
            chk("drain.data", drain_data, 512'(32'h10 + i));
            tick();
        end
        drain_ready = 1'b0;
        chk_status("drain4", 0, 1'b1, 1'b0);

        // All reservations consumed: an extra fill is an overflow.
        fill_valid = 1'b1;
        fill_data  = 512'h99;
        tick();
        fill_valid = 1'b0;
        chk("fill5.err_ov", 512'(err_overflow), 512'(1));
        chk("fill5.count", 512'(status.count), 512'(0));

        do_reset();

        // Enqueue collides with a fill: fill waits one cycle.
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        control.cmd = e_BUFFER_ENQUEUE;
        enq_data    = 512'hE1;
        fill_valid  = 1'b1;
        fill_data   = 512'hF1;
        settle();
        chk("coll.fill_ready0", 512'(fill_ready), 512'(0));
        tick();
        chk("coll.count1", 512'(status.count), 512'(1));
        control.cmd = e_BUFFER_IDLE;
        settle();
        chk("coll.fill_ready1", 512'(fill_ready), 512'(1));
        tick();
        fill_valid = 1'b0;
        chk("coll.count2", 512'(status.count), 512'(2));
        chk("coll.head", head_data, 512'hE1);

        // Simultaneous enqueue and drain at count 2; pointers wrap 3 -> 0.
        drain_ready = 1'b1;
        control.cmd = e_BUFFER_ENQUEUE;
        enq_data = 512'h21; settle(); chk("wrap.d0", drain_data, 512'hE1); tick(); chk("wrap.c0", 512'(status.count), 512'(2));
        enq_data = 512'h22; settle(); chk("wrap.d1", drain_data, 512'hF1); tick(); chk("wrap.c1", 512'(status.count), 512'(2));
        enq_data = 512'h23; settle(); chk("wrap.d2", drain_data, 512'h21); tick(); chk("wrap.c2", 512'(status.count), 512'(2));
        enq_data = 512'h24; settle(); chk("wrap.d3", drain_data, 512'h22); tick(); chk("wrap.c3", 512'(status.count), 512'(2));
        drain_ready = 1'b0;
        control.cmd = e_BUFFER_DEQUEUE;
        settle();
        chk("wrap.head0", head_data, 512'h23);
        tick();
        chk("wrap.head1", head_data, 512'h24);
        tick();
        chk_status("wrap.end", 0, 1'b1, 1'b0);

        // count=3 plus one reservation, then overflow, then reset.
        control.cmd = e_BUFFER_ENQUEUE;
        for (int i = 0; i < 3; i++) begin
            enq_data = 512'(32'h31 + i);
            tick();
        end
        control.cmd = e_BUFFER_IDLE;
        alloc_valid = 1'b1;
        settle();
        chk("pre.grant", 512'(alloc_grant), 512'(1));
        tick();
        alloc_valid = 1'b0;
        chk_status("pre", 3, 1'b0, 1'b1);
        chk("pre.head", head_data, 512'h31);
        control.cmd = e_BUFFER_ENQUEUE;
        enq_data    = 512'h34;
        tick();
        control.cmd = e_BUFFER_IDLE;
        chk("pre.err_ov", 512'(err_overflow), 512'(1));

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_status("rst3", 0, 1'b1, 1'b0);
        chk("rst3.err_ov", 512'(err_overflow), 512'(0));
        chk("rst3.err_un", 512'(err_underflow), 512'(0));
        chk("rst3.drain_valid", 512'(drain_valid), 512'(0));
        chk("rst3.grant", 512'(alloc_grant), 512'(0));

        // The reservation was discarded, so a stray fill is dropped.
        fill_valid = 1'b1;
        fill_data  = 512'h77;
        tick();
        fill_valid = 1'b0;
        chk("rst3.fill_drop", 512'(err_overflow), 512'(1));
        chk("rst3.fill_count", 512'(status.count), 512'(0));
        alloc_valid = 1'b1;
        settle();
        chk("rst3.grant_free", 512'(alloc_grant), 512'(1));
        alloc_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
